// File: rtl/mips_pkg.sv
// Shared op codes and FSM state encoding for the HI/LO multiply/divide unit.
package mips_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/mips_muldiv_unit_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on unsigned magnitudes.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_acc_hi,
  input  logic [WIDTH-1:0] i_acc_lo,
  input  logic [WIDTH-1:0] i_opb,
  output logic [WIDTH-1:0] o_acc_hi,
  output logic [WIDTH-1:0] o_acc_lo
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  // Multiply keeps the multiplier in acc_lo and shifts the product in from the top;
  // divide shifts dividend bits out of acc_lo into the partial remainder in acc_hi.
  always_comb begin
    w_sum    = {1'b0, i_acc_hi} + (i_acc_lo[0] ? {1'b0, i_opb} : {(WIDTH+1){1'b0}});
    w_rem_sh = {i_acc_hi, i_acc_lo[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, i_opb};
    if (i_div) begin
      if (!w_diff[WIDTH]) begin
        o_acc_hi = w_diff[WIDTH-1:0];
        o_acc_lo = {i_acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        o_acc_hi = w_rem_sh[WIDTH-1:0];
        o_acc_lo = {i_acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      o_acc_hi = w_sum[WIDTH:1];
      o_acc_lo = {w_sum[0], i_acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: WIDTH+1 cycle MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  md_state_t          r_state;
  md_state_t          w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_opb;
  logic               r_div;
  logic               r_div0;
  logic               r_neg_q;
  logic               r_neg_r;

  logic               w_launch;
  logic               w_is_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  assign w_launch = start && !flush &&
                    (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU);
  assign w_is_div = (op == MD_DIV) || (op == MD_DIVU);
  assign w_a_neg  = (op == MD_MULT || op == MD_DIV) && src_a[WIDTH-1];
  assign w_b_neg  = (op == MD_MULT || op == MD_DIV) && src_b[WIDTH-1];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div    (r_div),
    .i_acc_hi (r_acc_hi),
    .i_acc_lo (r_acc_lo),
    .i_opb    (r_opb),
    .o_acc_hi (w_step_hi),
    .o_acc_lo (w_step_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MD_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MD_IDLE: if (w_launch) w_next = MD_RUN;
      MD_RUN: begin
        if (flush) w_next = MD_IDLE;
        else if (r_cnt == LAST_STEP) w_next = MD_FIX;
      end
      MD_FIX:  w_next = MD_IDLE;
      default: w_next = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != MD_IDLE);
  end

  // Signs are reapplied to the unsigned magnitudes; a zero divisor forces an all-ones quotient.
  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    if (r_div) begin
      w_res_lo = r_div0 ? {WIDTH{1'b1}} : cneg(r_acc_lo, r_neg_q);
      w_res_hi = cneg(r_acc_hi, r_neg_r);
    end else begin
      {w_res_hi, w_res_lo} = cneg2({r_acc_hi, r_acc_lo}, r_neg_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          r_cnt <= '0;
          if (start && !flush && op == MD_MTHI) r_hi <= src_a;
          if (start && !flush && op == MD_MTLO) r_lo <= src_a;
        end
        MD_RUN:  r_cnt <= r_cnt + 1'b1;
        MD_FIX: begin
          if (!flush) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Operand/accumulator registers carry no reset: they are always loaded before use.
  always_ff @(posedge clk) begin
    if (r_state == MD_IDLE && w_launch) begin
      r_div    <= w_is_div;
      r_div0   <= w_is_div && (src_b == '0);
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_acc_hi <= '0;
      r_acc_lo <= cneg(src_a, w_a_neg);
      r_opb    <= cneg(src_b, w_b_neg);
    end else if (r_state == MD_RUN) begin
      r_acc_hi <= w_step_hi;
      r_acc_lo <= w_step_lo;
    end
  end

  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Randomised bench for mips_muldiv_unit with a transaction-level HI/LO reference model.
module tb_mips_muldiv_unit;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, flush, busy, done;
  logic [2:0]  op;
  logic [31:0] src_a, src_b, hi, lo;

  logic        start8, flush8, busy8, done8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mips_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .src_a(a8), .src_b(b8),
    .flush(flush8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural result of an op, from plain integer arithmetic: {hi, lo}.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [31:0]     q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return 64'(ua * ub);
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = 32'(ua / ub);
        r = 32'(ua % ub);
        return {r, q};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Reference model: an op occupies the unit for 33 cycles, then commits its result.
  int          m_left;
  logic [63:0] m_pend;
  logic [31:0] m_hi, m_lo;
  logic        m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (flush) begin
          m_left <= 0;
        end else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi   <= m_pend[63:32];
            m_lo   <= m_pend[31:0];
            m_done <= 1'b1;
          end
        end
      end else if (start && !flush) begin
        if (op <= OP_DIVU) begin
          m_pend <= ref_op(op, src_a, src_b);
          m_left <= 33;
        end else if (op == OP_MTHI) begin
          m_hi <= src_a;
        end else if (op == OP_MTLO) begin
          m_lo <= src_a;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_left > 0));
      chk("done", 64'(done), 64'(m_done));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int flush_at, input bit flush_with_start, output int ncyc);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; flush = flush_with_start;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    ncyc = 0;
    while (busy && ncyc < 100) begin
      if (ncyc == flush_at - 1) flush = 1'b1;
      ncyc++;
      @(negedge clk);
      flush = 1'b0;
    end
    if (ncyc >= 100) begin
      n_chk++;
      n_err++;
      $display("FAIL timeout: busy still %0d after %0d cycles, required 0", busy, ncyc);
    end
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int ncyc);
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0;
    ncyc = 0;
    while (busy8 && ncyc < 100) begin
      ncyc++;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(1, 100));
      default: return $urandom;
    endcase
  endfunction

  int          ncyc;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b;
  int          r_fa;
  bit          r_fs;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    start8 = 1'b0; flush8 = 1'b0; op8 = 3'd0; a8 = 8'd0; b8 = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    chk("model_div_neg", ref_op(OP_DIV, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("model_multu", ref_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    chk("model_div_ovf", ref_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    chk("model_div0", ref_op(OP_DIV, 32'd5, 32'd0), 64'h0000_0005_FFFF_FFFF);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, -1, 1'b0, ncyc);
    chk("mult_latency", 64'(ncyc), 64'd33);
    chk("mult_done", 64'(done), 64'd1);
    chk("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, ncyc);
    chk("multu_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, -1, 1'b0, ncyc);
    chk("mult_min_res", {hi, lo}, 64'h4000_0000_0000_0000);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, ncyc);
    chk("div_neg_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(OP_DIVU, 32'd7, 32'd2, -1, 1'b0, ncyc);
    chk("divu_res", {hi, lo}, 64'h0000_0001_0000_0003);
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, -1, 1'b0, ncyc);
    chk("div_negb_res", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
    issue(OP_DIV, 32'd5, 32'd0, -1, 1'b0, ncyc);
    chk("div0_res", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, ncyc);
    chk("div_ovf_res", {hi, lo}, 64'h0000_0000_8000_0000);

    issue(OP_MTHI, 32'h0000_1234, 32'd0, -1, 1'b0, ncyc);
    chk("mthi_nobusy", 64'(ncyc), 64'd0);
    chk("mthi_hi", 64'(hi), 64'h1234);

    issue(OP_MULT, 32'd3, 32'd4, -1, 1'b0, ncyc);
    issue(OP_DIV, 32'd100, 32'd7, 10, 1'b0, ncyc);
    chk("flush_cycles", 64'(ncyc), 64'd10);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_keep", {hi, lo}, 64'h0000_0000_0000_000C);
    issue(OP_DIV, 32'd100, 32'd7, -1, 1'b1, ncyc);
    chk("start_flush_busy", 64'(busy), 64'd0);
    issue(OP_MTHI, 32'hDEAD, 32'd0, -1, 1'b1, ncyc);
    chk("start_flush_mthi", 64'(hi), 64'd0);

    @(negedge clk);
    start = 1'b1; op = OP_MULT; src_a = 32'd6; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = OP_MTHI; src_a = 32'hBEEF;
    @(negedge clk);
    start = 1'b0;
    ncyc = 0;
    while (busy && ncyc < 100) begin
      ncyc++;
      @(negedge clk);
    end
    chk("start_in_busy", {hi, lo}, 64'h0000_0000_0000_002A);

    @(negedge clk);
    start = 1'b1; op = OP_MULT; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hi", 64'(hi), 64'd0);
    chk("async_rst_lo", 64'(lo), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = pick();
      r_b  = pick();
      r_fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 34)) : -1;
      r_fs = ($urandom_range(0, 9) == 0);
      issue(r_op, r_a, r_b, r_fa, r_fs, ncyc);
    end

    issue8(OP_MULT, 8'h80, 8'hFF, ncyc);
    chk("w8_mult_latency", 64'(ncyc), 64'd9);
    chk("w8_mult_done", 64'(done8), 64'd1);
    chk("w8_mult_res", 64'({hi8, lo8}), 64'h0080);
    issue8(OP_DIVU, 8'd200, 8'd3, ncyc);
    chk("w8_divu_res", 64'({hi8, lo8}), 64'h0242);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
